imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time stage directly upstream of the single-cycle CPU.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes those words into the instruction memory write port, then asserts cpu_run.
- cpu_run releases the CPU's PC; while cpu_run=0 the CPU is held at address 0.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- MAX_WORDS, 256, largest program length accepted; must be ≤ 2^ADDR_W.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-low reset, sampled on the rising edge of CLK.
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- byte_in  in  8  stream data byte.
- byte_valid  in  1  byte_in is valid this cycle.
- byte_ready  out  1  loader accepts a byte this cycle.
- im_we  out  1  instruction-memory write enable, one-cycle pulse per word.
- im_addr  out  ADDR_W  word address for the write.
- im_wdata  out  32  assembled instruction word.
- cpu_run  out  1  1 = CPU may fetch; 0 = CPU PC held at 0.
- words_loaded  out  ADDR_W+1  number of words written so far.
- error  out  1  sticky; set when the length header is invalid.

Behaviour:
- Reset (Reset=0 at a clock edge) forces all of the following:
  - state=IDLE.
  - byte_ready=0, im_we=0, im_addr=0, im_wdata=0.
  - cpu_run=0, words_loaded=0, error=0.
  - Byte counter, length register and the shift register are cleared.
- Reset mid-load aborts immediately. Partially written memory contents are left as-is.
- Handshake:
  - A byte transfers in a cycle where byte_valid=1 and byte_ready=1.
  - byte_ready is a registered output and does not depend combinationally on byte_valid.
  - byte_ready=1 only in HDR0, HDR1 and DATA.
- States and transitions:
  - IDLE: on start=1, go to HDR0; clear words_loaded, error and cpu_run.
  - HDR0: on transfer, len[15:8]=byte_in; go to HDR1.
  - HDR1: on transfer, len[7:0]=byte_in.
    - If the resulting len==0 or len>MAX_WORDS, go to ERR.
    - Otherwise go to DATA.
  - DATA: on each transfer, shift byte_in into word[7:0] (first byte lands in [31:24]) and increment the 2-bit byte counter.
    - On the 4th byte: in the next cycle im_we=1, im_wdata=the word, im_addr=words_loaded[ADDR_W-1:0]. words_loaded increments in that same cycle.
    - Write latency is 1 cycle after the 4th byte's accept edge.
    - byte_ready stays 1 during the write cycle; back-to-back words sustain 1 byte/cycle.
  - After the write of word len-1, go to DONE in the same edge that raises im_we, so byte_ready drops one cycle after the last byte.
  - DONE: cpu_run=1; byte_ready=0. Further bytes are ignored (not accepted).
  - ERR: error=1; cpu_run=0; byte_ready=0.
  - start in DONE or ERR: go to HDR0, cpu_run→0, error→0, words_loaded→0.
  - start in HDR0, HDR1 or DATA is ignored.
- Boundaries:
  - len==MAX_WORDS: the last write goes to im_addr=MAX_WORDS-1; words_loaded=MAX_WORDS. No wrap.
  - Idle cycles (byte_valid=0) in the middle of a word hold all state.
  - Simultaneous start and Reset=0: reset wins.
- Invariant: im_we is never 1 while cpu_run=1.

Decomposition:
- Shared package loader_pkg holds:
  - the state encoding: IDLE=0, HDR0=1, HDR1=2, DATA=3, DONE=4, ERR=5;
  - the constant BYTES_PER_WORD=4.
- One natural sub-module: byte_packer. It holds the shift register plus the 2-bit counter, with outputs word and word_done.
- The FSM, address/length counters and output registers stay in imem_loader.

Test Plan:
- Reset then start; stream 00 02 | 20 08 00 05 | 01 09 50 20 with byte_valid held at 1.
  - im_we pulses twice: addr 0 data 0x20080005, then addr 1 data 0x01095020.
  - Then cpu_run=1 and words_loaded=2.
- Header 00 00 → error=1, cpu_run=0, no im_we. A new start clears error and returns to HDR0.
- Header 01 01 (257 > MAX_WORDS=256) → ERR. The following data bytes are not accepted (byte_ready=0).
- Header 00 01, bytes AA BB CC DD with byte_valid low for 3 cycles between each byte → a single write of 0xAABBCCDD at addr 0; cpu_run=1.
- Reset=0 asserted after the 6th data byte of a 2-word load → all outputs return to their reset values next edge; a fresh start/load of 1 word succeeds.
- len=256 with a continuous stream → 256 writes, last at addr 0xFF; words_loaded=256.
  - Extra bytes after DONE are never accepted.
  - start and Reset=0 in the same cycle → reset state.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR0 = 3'd1,
        HDR1 = 3'd2,
        DATA = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_packer.sv
// Packs a big-endian byte stream into 32-bit words; word/word_done are valid
// combinationally in the cycle the last byte of a word is shifted in.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_done
);

    logic [23:0] shift_reg;
    logic [1:0]  count;

    // Earlier bytes sit in the upper lanes; the current byte completes the word.
    assign word      = {shift_reg, byte_in};
    assign word_done = shift_en && (count == 2'(BYTES_PER_WORD - 1));

    // Shift register and byte counter; cleared on reset or at the start of a load.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            shift_reg <= '0;
            count     <= '0;
        end else if (shift_en) begin
            shift_reg <= {shift_reg[15:0], byte_in};
            count     <= count + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length header and big-endian instruction bytes,
// writes the assembled words into instruction memory, then releases the CPU.
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_run,
    output logic [ADDR_W:0]   words_loaded,
    output logic              error
);

    state_t            state, state_n;
    logic [15:0]       len, len_n;
    logic [ADDR_W:0]   words_n, words_inc;
    logic [ADDR_W-1:0] addr_n;
    logic [31:0]       wdata_n;
    logic              we_n, ready_n, run_n, error_n;
    logic              transfer, packer_clear, shift_en;
    logic [31:0]       word;
    logic              word_done;

    assign transfer  = byte_valid && byte_ready;
    assign shift_en  = transfer && (state == DATA);
    assign words_inc = words_loaded + (ADDR_W+1)'(1);

    byte_packer u_packer (
        .clk       (CLK),
        .rst_n     (Reset),
        .clear     (packer_clear),
        .shift_en  (shift_en),
        .byte_in   (byte_in),
        .word      (word),
        .word_done (word_done)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_n      = state;
        len_n        = len;
        words_n      = words_loaded;
        addr_n       = im_addr;
        wdata_n      = im_wdata;
        we_n         = 1'b0;
        packer_clear = 1'b0;

        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_n      = HDR0;
                    len_n        = '0;
                    words_n      = '0;
                    packer_clear = 1'b1;
                end
            end
            HDR0: begin
                if (transfer) begin
                    len_n[15:8] = byte_in;
                    state_n     = HDR1;
                end
            end
            HDR1: begin
                if (transfer) begin
                    len_n[7:0] = byte_in;
                    if (len_n == '0 || 32'(len_n) > MAX_WORDS) state_n = ERR;
                    else                                       state_n = DATA;
                end
            end
            DATA: begin
                if (word_done) begin
                    we_n    = 1'b1;
                    addr_n  = words_loaded[ADDR_W-1:0];
                    wdata_n = word;
                    words_n = words_inc;
                    if (32'(words_inc) == 32'(len)) state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase

        ready_n = (state_n == HDR0) || (state_n == HDR1) || (state_n == DATA);
        // cpu_run lags DONE entry by one cycle so it never overlaps the final write.
        run_n   = (state == DONE) && (state_n == DONE);
        error_n = (state_n == ERR);
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state        <= IDLE;
            len          <= '0;
            byte_ready   <= 1'b0;
            im_we        <= 1'b0;
            im_addr      <= '0;
            im_wdata     <= '0;
            cpu_run      <= 1'b0;
            words_loaded <= '0;
            error        <= 1'b0;
        end else begin
            state        <= state_n;
            len          <= len_n;
            byte_ready   <= ready_n;
            im_we        <= we_n;
            im_addr      <= addr_n;
            im_wdata     <= wdata_n;
            cpu_run      <= run_n;
            words_loaded <= words_n;
            error        <= error_n;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: header table, random programs, corner sequences.
module tb_imem_loader;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned MAX_WORDS = 256;

    logic              CLK = 1'b0;
    logic              Reset = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        byte_in = '0;
    logic              byte_valid = 1'b0;
    logic              byte_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_run;
    logic [ADDR_W:0]   words_loaded;
    logic              error;

    int total = 0;
    int bad   = 0;

    // Reference model: the writes a correct loader must perform, in order.
    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_data[$];
    logic [31:0]       prog[0:MAX_WORDS-1];

    typedef struct {
        int unsigned len;
        bit          exp_err;
    } hdr_vec_t;

    hdr_vec_t vecs[8];

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .start        (start),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .im_we        (im_we),
        .im_addr      (im_addr),
        .im_wdata     (im_wdata),
        .cpu_run      (cpu_run),
        .words_loaded (words_loaded),
        .error        (error)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Write monitor: every im_we pulse must match the next expected write.
    always @(negedge CLK) begin
        if (im_we) begin
            chk("we_while_run", cpu_run, 1'b0);
            if (exp_addr.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0h data %h want no write", im_addr, im_wdata);
            end else begin
                chk("write_addr", im_addr, exp_addr.pop_front());
                chk("write_data", im_wdata, exp_data.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ready"}, byte_ready, 1'b0);
        chk({tag, "_we"}, im_we, 1'b0);
        chk({tag, "_addr"}, im_addr, '0);
        chk({tag, "_wdata"}, im_wdata, '0);
        chk({tag, "_run"}, cpu_run, 1'b0);
        chk({tag, "_words"}, words_loaded, '0);
        chk({tag, "_error"}, error, 1'b0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ready", byte_ready, 1'b1);
        chk("start_error", error, 1'b0);
        chk("start_run", cpu_run, 1'b0);
        chk("start_words", words_loaded, '0);
    endtask

    // Offer one byte and hold it until accepted (bounded).
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_valid = 1'b1;
        byte_in    = b;
        while (!byte_ready && n < 20) begin
            tick();
            n++;
        end
        chk("byte_accepted", byte_ready, 1'b1);
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap, input bit last);
        for (int b = 3; b >= 0; b--) begin
            send_byte(w[8*b +: 8]);
            if (!(last && b == 0)) repeat (gap) tick();
        end
    endtask

    // Full load of prog[0..len-1]; expected writes come from the program itself.
    task automatic run_load(input int unsigned len, input int gap);
        logic [15:0] l16;
        l16 = 16'(len);
        for (int unsigned i = 0; i < len; i++) begin
            exp_addr.push_back(ADDR_W'(i));
            exp_data.push_back(prog[i]);
        end
        do_start();
        send_byte(l16[15:8]);
        send_byte(l16[7:0]);
        chk("hdr_error", error, 1'b0);
        for (int unsigned i = 0; i < len; i++) send_word(prog[i], gap, i == len - 1);
        chk("last_ready_drop", byte_ready, 1'b0);
        chk("last_run_low", cpu_run, 1'b0);
        chk("last_words", words_loaded, (ADDR_W+1)'(len));
        tick();
        chk("done_run", cpu_run, 1'b1);
        chk("done_error", error, 1'b0);
        chk("done_words", words_loaded, (ADDR_W+1)'(len));
        chk("writes_pending", exp_addr.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 1'b1};
        vecs[1] = '{257, 1'b1};
        vecs[2] = '{16'hFFFF, 1'b1};
        vecs[3] = '{16'h8000, 1'b1};
        vecs[4] = '{1, 1'b0};
        vecs[5] = '{2, 1'b0};
        vecs[6] = '{3, 1'b0};
        vecs[7] = '{7, 1'b0};

        // Reset state
        repeat (3) tick();
        check_reset_state("reset");
        Reset = 1'b1;
        tick();
        chk("idle_ready", byte_ready, 1'b0);

        // Reference two-word program, continuous stream
        prog[0] = 32'h20080005;
        prog[1] = 32'h01095020;
        run_load(2, 0);

        // Idle gaps of 3 cycles between every byte
        prog[0] = 32'hAABBCCDD;
        run_load(1, 3);

        // start in DATA is ignored
        exp_addr.push_back('0);
        exp_data.push_back(32'h12345678);
        do_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h12);
        send_byte(8'h34);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_start_ready", byte_ready, 1'b1);
        chk("ign_start_words", words_loaded, '0);
        send_byte(8'h56);
        send_byte(8'h78);
        tick();
        chk("ign_start_run", cpu_run, 1'b1);
        chk("ign_start_pending", exp_addr.size(), 0);

        // Reset after the 6th data byte of a two-word load
        prog[0] = $urandom();
        prog[1] = $urandom();
        exp_addr.push_back('0);
        exp_data.push_back(prog[0]);
        do_start();
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(prog[0], 0, 1'b0);
        send_byte(prog[1][31:24]);
        send_byte(prog[1][23:16]);
        Reset = 1'b0;
        tick();
        check_reset_state("midreset");
        Reset = 1'b1;
        chk("midreset_pending", exp_addr.size(), 0);
        prog[0] = $urandom();
        run_load(1, 0);

        // Header table: invalid lengths go to ERR, valid ones load random programs
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].exp_err) begin
                do_start();
                send_byte(8'(vecs[v].len >> 8));
                send_byte(8'(vecs[v].len));
                chk("err_flag", error, 1'b1);
                chk("err_ready", byte_ready, 1'b0);
                chk("err_run", cpu_run, 1'b0);
                byte_valid = 1'b1;
                byte_in    = 8'($urandom());
                repeat (3) begin
                    tick();
                    chk("err_no_accept", byte_ready, 1'b0);
                end
                byte_valid = 1'b0;
                chk("err_words", words_loaded, '0);
                chk("err_sticky", error, 1'b1);
            end else begin
                for (int unsigned i = 0; i < vecs[v].len; i++) prog[i] = $urandom();
                run_load(vecs[v].len, int'($urandom_range(0, 2)));
            end
        end

        // Maximum length, continuous stream: last write at addr 0xFF
        for (int unsigned i = 0; i < MAX_WORDS; i++) prog[i] = $urandom();
        run_load(MAX_WORDS, 0);
        byte_valid = 1'b1;
        byte_in    = 8'hEE;
        repeat (4) begin
            tick();
            chk("done_no_accept", byte_ready, 1'b0);
            chk("done_words_hold", words_loaded, (ADDR_W+1)'(MAX_WORDS));
        end
        byte_valid = 1'b0;

        // start and reset together: reset wins
        start = 1'b1;
        Reset = 1'b0;
        tick();
        check_reset_state("start_reset");
        start = 1'b0;
        Reset = 1'b1;
        tick();
        chk("start_reset_idle", byte_ready, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
